// File: rtl/foo_drv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | foo_drv_pkg: shared types and vector generator for foo_stim_driver |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package foo_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Width of the buffered vector index; the driver's COUNT_W must not exceed it.
  localparam int RSP_INDEX_W = 16;

  typedef struct packed {
    logic [RSP_INDEX_W-1:0] index;
    logic [31:0]            x1;
    logic [31:0]            x0;
  } rsp_t;

  function automatic logic [31:0] next_vec(input logic [31:0] v, input logic mode);
    if (mode) begin
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    end
    return v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/foo_rsp_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | foo_rsp_fifo: show-ahead response FIFO with occupancy output     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module foo_rsp_fifo
  import foo_drv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rsp_t                   push_data,
  input  logic                   pop,
  output rsp_t                   pop_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so stale entries never reach the port.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/foo_stim_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | foo_stim_driver: drives a0/a1 stimulus, collects x0/x1 responses |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module foo_stim_driver
  import foo_drv_pkg::*;
#(
  parameter int FOO_LATENCY = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic [31:0]        seed,
  input  logic               mode,
  output logic [31:0]        a0,
  output logic [31:0]        a1,
  input  logic [31:0]        x0,
  input  logic [31:0]        x1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  output logic [COUNT_W-1:0] rsp_index,
  output logic               busy,
  output logic               done
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;

  logic [31:0]        vec_q;
  logic [COUNT_W-1:0] idx_q;
  logic [COUNT_W-1:0] nvec_q;
  logic               mode_q;

  logic [FOO_LATENCY-1:0] flag_sr;
  logic [COUNT_W-1:0]     idx_sr [FOO_LATENCY];

  logic [LW-1:0]      inflight;
  logic [LW-1:0]      fifo_level;
  logic               credit;
  logic               launch;
  logic               issue;
  logic               last;
  logic               cap;

  logic [31:0]        seed_eff;
  logic [31:0]        cur_vec;
  logic [COUNT_W-1:0] cur_idx;
  logic [COUNT_W-1:0] cur_nvec;
  logic               cur_mode;

  rsp_t               push_rsp;
  rsp_t               pop_rsp;

  assign seed_eff = (mode && (seed == 32'h0)) ? 32'd1 : seed;
  assign launch   = (state == ST_IDLE) && start && (num_vec != '0);
  assign cap      = flag_sr[FOO_LATENCY-1];

  // Responses already buffered plus those still in flight must fit in the FIFO.
  assign credit = ({1'b0, fifo_level} + {1'b0, inflight}) < (LW + 1)'(FIFO_DEPTH);

  // In IDLE the first vector comes straight from the start-time inputs.
  always_comb begin
    cur_vec  = vec_q;
    cur_idx  = idx_q;
    cur_nvec = nvec_q;
    cur_mode = mode_q;
    if (state == ST_IDLE) begin
      cur_vec  = seed_eff;
      cur_idx  = '0;
      cur_nvec = num_vec;
      cur_mode = mode;
    end
    last  = (cur_idx == (cur_nvec - COUNT_W'(1)));
    issue = credit && (launch || (state == ST_ISSUE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_vec == '0)     state_nxt = ST_DONE;
          else if (issue && last) state_nxt = ST_DRAIN;
          else                    state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (issue && last)     state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0)    state_nxt = ST_DONE;
      ST_DONE:                         state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0       <= '0;
      a1       <= '0;
      vec_q    <= '0;
      idx_q    <= '0;
      nvec_q   <= '0;
      mode_q   <= 1'b0;
      flag_sr  <= '0;
      inflight <= '0;
      for (int i = 0; i < FOO_LATENCY; i++) idx_sr[i] <= '0;
    end else begin
      if (launch) begin
        mode_q <= mode;
        nvec_q <= num_vec;
      end
      if (issue) begin
        a0    <= cur_vec;
        a1    <= ~cur_vec;
        vec_q <= next_vec(cur_vec, cur_mode);
        idx_q <= cur_idx + COUNT_W'(1);
      end else if (launch) begin
        vec_q <= seed_eff;
        idx_q <= '0;
      end
      flag_sr[0] <= issue;
      idx_sr[0]  <= cur_idx;
      for (int i = 1; i < FOO_LATENCY; i++) begin
        flag_sr[i] <= flag_sr[i-1];
        idx_sr[i]  <= idx_sr[i-1];
      end
      inflight <= inflight + LW'(issue) - LW'(cap);
    end
  end

  assign push_rsp = '{index: RSP_INDEX_W'(idx_sr[FOO_LATENCY-1]), x1: x1, x0: x0};

  foo_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cap),
    .push_data(push_rsp),
    .pop      (rsp_ready),
    .pop_data (pop_rsp),
    .valid    (rsp_valid),
    .level    (fifo_level)
  );

  assign rsp_data  = {pop_rsp.x1, pop_rsp.x0};
  assign rsp_index = COUNT_W'(pop_rsp.index);
  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/foo_stim_driver.md
# foo_stim_driver

Stimulus source and response collector for the two-lane `foo_tb` interface. It drives `a0`/`a1` with a generated vector sequence and samples `x0`/`x1` a fixed `FOO_LATENCY` cycles later. Captured responses are buffered in order and delivered on a valid/ready stream. It sits on the far side of `foo_tb`, replacing hand-written stimulus in regression and bring-up.

## Interface
- `FOO_LATENCY`, 1: cycles from `a*` change to matching `x*`; must be ≥1.
- `FIFO_DEPTH`, 8: response buffer entries; power of two, ≥2.
- `COUNT_W`, 16: width of vector count and index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; ignored unless idle.
- `num_vec` in COUNT_W: vectors per run, sampled with `start`.
- `seed` in 32: first vector value, sampled with `start`.
- `mode` in 1: sampled with `start`; 0 = increment, 1 = LFSR.
- `a0`, `a1` out 32: stimulus to `foo_tb`, registered.
- `x0`, `x1` in 32: responses from `foo_tb`.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_data` out 64: `{x1, x0}`.
- `rsp_index` out COUNT_W: vector number, 0-based.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle end-of-run pulse.

## Operation
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start` with `num_vec`≠0 → ISSUE.
  - `start` with `num_vec`=0 → DONE; `a*` are unchanged.
- Issuing a vector:
  - Condition: FIFO occupancy + in-flight count < FIFO_DEPTH.
  - Drive `a0`=v, `a1`=~v.
  - Push issue-flag and index into a FOO_LATENCY-deep shift line.
  - Advance v.
  - Without credit: `a*` hold their last value and nothing is pushed.
- Generator:
  - Increment mode: v+1, wrapping modulo 2^32.
  - LFSR mode: Galois right-shift, mask 0x8020_0003, i.e. `v = (v>>1) ^ (v[0] ? mask : 0)`. A seed of 0 is replaced by 1.
- Capture: when the flag exits the shift line, `{x1,x0}` and the index are written to the FIFO on that edge. FIFO overflow cannot occur because of credit gating.
- State transitions:
  - After vector `num_vec`−1 issues → DRAIN.
  - DRAIN, once in-flight reaches 0 → DONE.
  - DONE lasts one cycle (`done`=1), then → IDLE.
- `busy`=1 in ISSUE and DRAIN.
- `done` does not wait for the FIFO to drain; responses may still be pending after `done`.
- `start` in a non-IDLE state is ignored.
- Reset (any time, including mid-run):
  - State = IDLE; FIFO and shift line cleared.
  - `a0`=`a1`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_index`=0, `busy`=0, `done`=0.

## Timing
- `start` is sampled at edge E. On the same edge vector 0 loads onto `a*` and `busy` rises.
- Without stalls, vector k is on `a*` during the cycle after edge E+k.
- Vector k's response is captured at edge E+k+FOO_LATENCY.
- `rsp_valid` is high in the cycle after the capture edge (show-ahead FIFO; zero extra latency).
- Without stalls, `done` is high in the cycle after edge E+num_vec+FOO_LATENCY, and `busy` falls on the same edge.
- For `num_vec`=0, `done` is high in the cycle after edge E.
- Handshake: a transfer occurs on `rsp_valid && rsp_ready`. `rsp_data` and `rsp_index` are stable while `rsp_valid && !rsp_ready`.
- A simultaneous push and pop is legal at any occupancy.

## Structure
- Package `foo_drv_pkg` contains:
  - the state enum;
  - `LFSR_MASK` = 32'h8020_0003;
  - function `next_vec(v, mode)`;
  - packed struct `rsp_t {index, x1, x0}`.
- Sub-module `foo_rsp_fifo`: synchronous show-ahead FIFO of `rsp_t`, parameterised by DEPTH, exposing occupancy for credit calculation.

## Test plan
- Reset mid-run: assert `rst_n` low at vector 5 of 10 → all outputs 0 immediately. After release, no `rsp_valid` and `busy`=0.
- Basic run:
  - Setup: increment mode, seed=0x10, `num_vec`=4, `rsp_ready`=1, loopback model x=a delayed by FOO_LATENCY=1.
  - Expected `a0`: 0x10..0x13.
  - Expected responses: `rsp_index` 0..3, with `rsp_data` = {0xFFFF_FFEF, 0x10} … {0xFFFF_FFEC, 0x13}.
  - `done` is high in the cycle after edge E+5.
- Backpressure:
  - Setup: `rsp_ready`=0, `num_vec`=20, DEPTH=8.
  - Expected: exactly 8 vectors issued; `a0` holds 0x17 and `busy` stays 1.
  - Then raise `rsp_ready` → all 20 responses arrive in order with none lost.
- LFSR mode, seed=0 → vectors 0x0000_0001, then 0x8020_0003.
- `num_vec`=0 → one-cycle `done`, `busy` never asserts, no `rsp_valid`, and `a*` are unchanged.
- Increment wrap with an ignored restart:
  - Setup: seed=0xFFFF_FFFF, `num_vec`=2; pulse `start` again during ISSUE.
  - Expected vectors: 0xFFFF_FFFF, then 0x0000_0000.
  - Exactly 2 responses and a single `done`.
